// File: rtl/wb_load_stage.sv
// Writeback stage: retires ALU results directly, issues data-memory reads for
// loads, aligns/extends the returned data and drives the register-file write port.
module wb_load_stage #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic        in_reg_write,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic        rf_we,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic [31:0] retired_count
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       lat_rd_q, lat_rd_d;
  logic [2:0]       lat_f3_q, lat_f3_d;
  logic [1:0]       lat_off_q, lat_off_d;
  logic             lat_rw_q, lat_rw_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_a3_q, rf_a3_d;
  logic [31:0]      rf_wd3_q, rf_wd3_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             err_mis_q, err_mis_d;
  logic             err_to_q, err_to_d;
  logic [31:0]      ret_q, ret_d;

  logic             misaligned;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic [CNT_W-1:0] cnt_inc;

  // Alignment / funct3 legality check on the incoming load; unsupported types count as misaligned.
  always_comb begin
    misaligned = 1'b1;
    unique case (in_funct3)
      F3Lb, F3Lbu: misaligned = 1'b0;
      F3Lh, F3Lhu: misaligned = in_result[0];
      F3Lw:        misaligned = (in_result[1:0] != 2'b00);
      default:     misaligned = 1'b1;
    endcase
  end

  // Extract and extend the addressed byte/half/word from the returned memory word.
  always_comb begin
    ld_byte = mem_rdata[8*lat_off_q +: 8];
    ld_half = lat_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (lat_f3_q)
      F3Lb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3Lbu:   ld_data = {24'h0, ld_byte};
      F3Lh:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3Lhu:   ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state logic for the FSM, latched load info and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_rd_d   = lat_rd_q;
    lat_f3_d   = lat_f3_q;
    lat_off_d  = lat_off_q;
    lat_rw_d   = lat_rw_q;
    rf_we_d    = 1'b0;
    rf_a3_d    = rf_a3_q;
    rf_wd3_d   = rf_wd3_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;
    ret_d      = ret_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!in_is_load) begin
            rf_we_d = in_reg_write && (in_rd != 5'd0);
            // Address/data only move when a write happens so they hold otherwise.
            if (rf_we_d) begin
              rf_a3_d  = in_rd;
              rf_wd3_d = in_result;
            end
            ret_d = ret_q + 32'd1;
          end else if (misaligned) begin
            err_mis_d = 1'b1;
            ret_d     = ret_q + 32'd1;
          end else begin
            lat_rd_d   = in_rd;
            lat_f3_d   = in_funct3;
            lat_off_d  = in_result[1:0];
            lat_rw_d   = in_reg_write;
            mem_req_d  = 1'b1;
            mem_addr_d = {in_result[31:2], 2'b00};
            cnt_d      = '0;
            state_d    = StWait;
          end
        end
      end
      default: begin
        if (mem_rvalid) begin
          rf_we_d = lat_rw_q && (lat_rd_q != 5'd0);
          if (rf_we_d) begin
            rf_a3_d  = lat_rd_q;
            rf_wd3_d = ld_data;
          end
          ret_d   = ret_q + 32'd1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) begin
            err_to_d = 1'b1;
            ret_d    = ret_q + 32'd1;
            state_d  = StIdle;
          end
        end
      end
    endcase
  end

  // State and output registers; reset aborts any outstanding load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lat_rd_q   <= '0;
      lat_f3_q   <= '0;
      lat_off_q  <= '0;
      lat_rw_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_a3_q    <= '0;
      rf_wd3_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
      ret_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_rd_q   <= lat_rd_d;
      lat_f3_q   <= lat_f3_d;
      lat_off_q  <= lat_off_d;
      lat_rw_q   <= lat_rw_d;
      rf_we_q    <= rf_we_d;
      rf_a3_q    <= rf_a3_d;
      rf_wd3_q   <= rf_wd3_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
      ret_q      <= ret_d;
    end
  end

  assign in_ready       = (state_q == StIdle);
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign rf_a3          = rf_a3_q;
  assign rf_wd3         = rf_wd3_q;
  assign rf_we          = rf_we_q;
  assign fwd_valid      = rf_we_q;
  assign fwd_rd         = rf_a3_q;
  assign fwd_data       = rf_wd3_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;
  assign retired_count  = ret_q;

endmodule
